// File: rtl/demux_pkg.sv
// Shared definitions for the chip-select generator: FSM state encoding.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/demux_cs_wait_if.sv
// Bus between the CPU-side address decode and the chip-select generator.
interface demux_cs_wait_if #(
  parameter int SEL_W = 3
) ();
  localparam int OUT_N = 1 << SEL_W;

  logic             en;
  logic [SEL_W-1:0] sel;
  logic [OUT_N-1:0] out;
  logic             rdy;
  logic             busy;

  modport master (output en, sel, input out, rdy, busy);
  modport slave  (input en, sel, output out, rdy, busy);
endinterface

// File: rtl/demux_nbit.sv
// Purely combinational SEL_W -> 2^SEL_W one-hot decoder.
module demux_nbit #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]        sel,
  output logic [(1<<SEL_W)-1:0]   onehot
);
  localparam int OUT_N = 1 << SEL_W;

  // One comparator per output bit; exactly one matches for any sel.
  for (genvar gi = 0; gi < OUT_N; gi++) begin : g_dec
    assign onehot[gi] = (sel == SEL_W'(gi));
  end
endmodule

// File: rtl/demux_cs_wait.sv
// Registered one-hot chip-select generator with per-output wait states.
// rdy/busy come only from the state register, never from en/sel.
module demux_cs_wait
  import demux_pkg::*;
#(
  parameter int                              SEL_W      = 3,
  parameter int                              WAIT_W     = 2,
  parameter logic [(1<<SEL_W)*WAIT_W-1:0]    WAIT_MAP   = '0,
  parameter bit                              ACTIVE_LOW = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  demux_cs_wait_if.slave   bus
);
  localparam int OUT_N = 1 << SEL_W;
  localparam logic [OUT_N-1:0] INACTIVE = ACTIVE_LOW ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

  state_t             state;
  logic [WAIT_W-1:0]  cnt;
  logic [SEL_W-1:0]   sel_q;
  logic [OUT_N-1:0]   out_q;
  logic [OUT_N-1:0]   onehot;
  logic [WAIT_W-1:0]  wait_tbl [OUT_N];
  logic [WAIT_W-1:0]  wait_sel;

  demux_nbit #(.SEL_W(SEL_W)) u_dec (
    .sel    (bus.sel),
    .onehot (onehot)
  );

  // Unpack the wait map into a table indexed by region select.
  for (genvar gi = 0; gi < OUT_N; gi++) begin : g_wait
    assign wait_tbl[gi] = WAIT_MAP[gi*WAIT_W +: WAIT_W];
  end

  assign wait_sel = wait_tbl[bus.sel];

  // Access FSM: accept from IDLE/ACTIVE, count down wait cycles, hold out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sel_q <= '0;
      out_q <= INACTIVE;
    end else begin
      case (state)
        ST_IDLE, ST_ACTIVE: begin
          if (bus.en) begin
            sel_q <= bus.sel;
            // XOR with the inactive pattern inverts for active-low outputs.
            out_q <= onehot ^ INACTIVE;
            if (wait_sel == '0) begin
              state <= ST_ACTIVE;
            end else begin
              state <= ST_WAIT;
              cnt   <= wait_sel;
            end
          end else begin
            state <= ST_IDLE;
            out_q <= INACTIVE;
          end
        end
        ST_WAIT: begin
          // Leave on cnt==1 so the counter never wraps below zero.
          if (cnt == WAIT_W'(1)) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          out_q <= INACTIVE;
        end
      endcase
    end
  end

  // sel_q records the region of the current access for debug visibility.
  logic unused_sel_q;
  assign unused_sel_q = ^sel_q;

  assign bus.out  = out_q;
  assign bus.rdy  = (state != ST_WAIT);
  assign bus.busy = (state != ST_IDLE);
endmodule

// File: tb/tb_demux_cs_wait.sv
// Directed bench for demux_cs_wait: one active-high and one active-low DUT.
module tb_demux_cs_wait;
  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  demux_cs_wait_if #(.SEL_W(3)) bus_a ();
  demux_cs_wait_if #(.SEL_W(3)) bus_b ();

  demux_cs_wait #(
    .SEL_W(3), .WAIT_W(2), .WAIT_MAP(16'hE4E4), .ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a)
  );

  demux_cs_wait #(
    .SEL_W(3), .WAIT_W(2), .WAIT_MAP(16'hE4E4), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] out_e,
                         input logic rdy_e, input logic busy_e);
    check({tag, ".out"},  32'(bus_a.out),  32'(out_e));
    check({tag, ".rdy"},  32'(bus_a.rdy),  32'(rdy_e));
    check({tag, ".busy"}, 32'(bus_a.busy), 32'(busy_e));
    check({tag, ".ones"}, 32'($countones(bus_a.out) <= 1), 32'd1);
  endtask

  task automatic check_b(input string tag, input logic [7:0] out_e,
                         input logic rdy_e, input logic busy_e);
    check({tag, ".out"},  32'(bus_b.out),  32'(out_e));
    check({tag, ".rdy"},  32'(bus_b.rdy),  32'(rdy_e));
    check({tag, ".busy"}, 32'(bus_b.busy), 32'(busy_e));
  endtask

  initial begin
    // Reset with a pending request that must be ignored.
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    bus_a.en = 1'b1; bus_a.sel = 3'd3;
    bus_b.en = 1'b0; bus_b.sel = 3'd0;
    tick();
    check_a("rst1", 8'h00, 1'b1, 1'b0);
    tick();
    check_a("rst2", 8'h00, 1'b1, 1'b0);
    check_b("rst_b", 8'hFF, 1'b1, 1'b0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    bus_a.en = 1'b0;
    tick();
    check_a("idle", 8'h00, 1'b1, 1'b0);

    // Zero-wait access on out0.
    bus_a.en = 1'b1; bus_a.sel = 3'd0;
    tick();
    bus_a.en = 1'b0;
    check_a("zw_act", 8'h01, 1'b1, 1'b1);
    tick();
    check_a("zw_idle", 8'h00, 1'b1, 1'b0);

    // Maximum wait on out3; sel changes during WAIT must not matter.
    bus_a.en = 1'b1; bus_a.sel = 3'd3;
    tick();
    bus_a.en = 1'b0; bus_a.sel = 3'd5;
    for (int i = 1; i <= 3; i++) begin
      check_a($sformatf("mw_wait%0d", i), 8'h08, 1'b0, 1'b1);
      tick();
    end
    check_a("mw_act", 8'h08, 1'b1, 1'b1);
    tick();
    check_a("mw_idle", 8'h00, 1'b1, 1'b0);

    // Single wait on out5.
    bus_a.en = 1'b1; bus_a.sel = 3'd5;
    tick();
    bus_a.en = 1'b0;
    check_a("w1_wait", 8'h20, 1'b0, 1'b1);
    tick();
    check_a("w1_act", 8'h20, 1'b1, 1'b1);
    tick();
    check_a("w1_idle", 8'h00, 1'b1, 1'b0);

    // Back-to-back: out4 (no wait) then out6 (two waits) with en held.
    bus_a.en = 1'b1; bus_a.sel = 3'd4;
    tick();
    check_a("b2b_a", 8'h10, 1'b1, 1'b1);
    bus_a.sel = 3'd6;
    tick();
    bus_a.en = 1'b0;
    check_a("b2b_w1", 8'h40, 1'b0, 1'b1);
    tick();
    check_a("b2b_w2", 8'h40, 1'b0, 1'b1);
    tick();
    check_a("b2b_act", 8'h40, 1'b1, 1'b1);
    tick();
    check_a("b2b_idle", 8'h00, 1'b1, 1'b0);

    // Active-low DUT: reset during the second WAIT cycle abandons the access.
    bus_b.en = 1'b1; bus_b.sel = 3'd2;
    tick();
    bus_b.en = 1'b0;
    check_b("al_w1", 8'hFB, 1'b0, 1'b1);
    tick();
    check_b("al_w2", 8'hFB, 1'b0, 1'b1);
    rst_n_b = 1'b0;
    tick();
    check_b("al_rst", 8'hFF, 1'b1, 1'b0);
    rst_n_b = 1'b1;
    tick();
    check_b("al_idle", 8'hFF, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
